inverter_bist_ctrl: RTL and testbench

INVERTER_BIST_CTRL -- requirements
Module: inverter_bist_ctrl

---
 rtl/inverter_bist_ctrl_if.sv | 34 +++
 rtl/inverter_bist_ctrl.sv | 153 +++++++++++++++
 tb/tb_inverter_bist_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/inverter_bist_ctrl_if.sv
// ----------------------------------------------------------------------------
// inverter_bist_ctrl_if
// Purpose : groups the run-control handshake and the inverter-under-test
//           stimulus/response pins of inverter_bist_ctrl into one bundle.
// Signals : start, abort     run request / cancel          (master -> slave)
//           dut_out          inverter output               (master -> slave)
//           dut_in           inverter input                (slave -> master)
//           busy, done, pass run status                    (slave -> master)
//           err_count        mismatch counter, ERR_W bits  (slave -> master)
// The slave modport is the BIST controller. The master modport is whatever
// requests runs and also models or connects the inverter.
// ----------------------------------------------------------------------------
interface inverter_bist_ctrl_if #(
   parameter int ERR_W = 8
);
   logic             start;
   logic             abort;
   logic             dut_in;
   logic             dut_out;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;

   modport master (
      output start, abort, dut_out,
      input  dut_in, busy, done, pass, err_count
   );

   modport slave (
      input  start, abort, dut_out,
      output dut_in, busy, done, pass, err_count
   );
endinterface

// File: rtl/inverter_bist_ctrl.sv
// ----------------------------------------------------------------------------
// inverter_bist_ctrl
// Purpose : built-in self test of a single inverter. The controller applies
//           NUM_VECTORS alternating vectors (0,1,0,1,...) on dut_in. For each
//           vector it waits SETTLE_CYCLES cycles, compares dut_out with
//           ~dut_in, and counts mismatches. The count saturates at
//           2^ERR_W-1.
// Ports   : clk   system clock, rising edge
//           rst_n asynchronous active-low reset
//           bist  inverter_bist_ctrl_if.slave
//                 (start/abort/dut_out in; dut_in/busy/done/pass/err_count out)
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; dut_in parked at 0
// APPLY  | drive dut_in = vec_idx[0], load settle timer
// SETTLE | settle timer counts down SETTLE_CYCLES cycles
// CHECK  | compare dut_out with ~dut_in, advance vector or finish
// DONE   | one-cycle done pulse, pass valid, return to IDLE
// ----------------------------------------------------------------------------
module inverter_bist_ctrl #(
   parameter int NUM_VECTORS   = 16,
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_W         = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   inverter_bist_ctrl_if.slave  bist
);

   localparam int IDX_W = (NUM_VECTORS > 2) ? $clog2(NUM_VECTORS) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_APPLY  = 3'd1,
      S_SETTLE = 3'd2,
      S_CHECK  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   vec_idx_q, vec_idx_d;
   logic [7:0]         settle_q, settle_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               pass_q, pass_d;
   logic               dut_in_q, dut_in_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               mismatch;
   logic               last_vec;
   logic               run_active;

   // A good inverter gives dut_out = ~dut_in. Equality is therefore a fault.
   assign mismatch   = (state_q == S_CHECK) && (bist.dut_out == dut_in_q);
   assign last_vec   = (vec_idx_q == IDX_W'(NUM_VECTORS - 1));
   assign run_active = (state_q == S_APPLY) || (state_q == S_SETTLE) ||
                       (state_q == S_CHECK);

   always_comb begin
      state_d   = state_q;
      vec_idx_d = vec_idx_q;
      settle_d  = settle_q;
      err_d     = err_q;
      pass_d    = pass_q;

      unique case (state_q)
         S_IDLE: begin
            if (bist.start && !bist.abort) begin
               state_d   = S_APPLY;
               vec_idx_d = '0;
               err_d     = '0;
               pass_d    = 1'b0;
            end
         end
         S_APPLY: begin
            settle_d = 8'(SETTLE_CYCLES);
            state_d  = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
         end
         S_SETTLE: begin
            settle_d = settle_q - 8'd1;
            // The timer holds SETTLE_CYCLES on the first SETTLE cycle.
            // Leaving at 1 gives exactly SETTLE_CYCLES cycles here.
            if (settle_q <= 8'd1) begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (mismatch && (err_q != {ERR_W{1'b1}})) begin
               err_d = err_q + 1'b1;
            end
            if (last_vec) begin
               state_d = S_DONE;
               pass_d  = (err_d == '0);
            end else begin
               vec_idx_d = vec_idx_q + 1'b1;
               state_d   = S_APPLY;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides the step but keeps any mismatch counted this cycle.
      if (bist.abort && run_active) begin
         state_d   = S_IDLE;
         pass_d    = 1'b0;
         vec_idx_d = vec_idx_q;
         settle_d  = '0;
      end
   end

   // Outputs are registered from the next-state values. They change on the
   // same edge as the state, and the analog pin sees no decode glitches.
   always_comb begin
      busy_d   = (state_d == S_APPLY) || (state_d == S_SETTLE) ||
                 (state_d == S_CHECK);
      done_d   = (state_d == S_DONE);
      dut_in_d = busy_d ? vec_idx_d[0] : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         vec_idx_q <= '0;
         settle_q  <= '0;
         err_q     <= '0;
         pass_q    <= 1'b0;
         dut_in_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         vec_idx_q <= vec_idx_d;
         settle_q  <= settle_d;
         err_q     <= err_d;
         pass_q    <= pass_d;
         dut_in_q  <= dut_in_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bist.dut_in    = dut_in_q;
   assign bist.busy      = busy_q;
   assign bist.done      = done_q;
   assign bist.pass      = pass_q;
   assign bist.err_count = err_q;

endmodule

// File: tb/tb_inverter_bist_ctrl.sv
// ----------------------------------------------------------------------------
// tb_inverter_bist_ctrl
// Purpose : self-checking bench for inverter_bist_ctrl. Three instances run:
//   u_a  defaults (16 vectors, settle 2, 8-bit count), driven cycle by cycle
//   u_b  ERR_W=3 with a buffer in place of the inverter
//   u_c  NUM_VECTORS=4, SETTLE_CYCLES=0 with a good inverter
// The expected values come from vector timing alone: vector v occupies cycles
// v*(S+2) .. v*(S+2)+S+1 after the start edge, and the last cycle is the
// compare. Mismatches are tallied and then saturated.
// ----------------------------------------------------------------------------
module tb_inverter_bist_ctrl;

   localparam int N   = 16;
   localparam int S   = 2;
   localparam int VPC = S + 2;
   localparam int RUN = N * VPC;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   inverter_bist_ctrl_if #(.ERR_W(8)) ifa ();
   inverter_bist_ctrl_if #(.ERR_W(3)) ifb ();
   inverter_bist_ctrl_if #(.ERR_W(8)) ifc ();

   assign ifb.dut_out = ifb.dut_in;
   assign ifc.dut_out = ~ifc.dut_in;

   inverter_bist_ctrl #(.NUM_VECTORS(16), .SETTLE_CYCLES(2), .ERR_W(8)) u_a (
      .clk(clk), .rst_n(rst_n), .bist(ifa)
   );
   inverter_bist_ctrl #(.NUM_VECTORS(16), .SETTLE_CYCLES(2), .ERR_W(3)) u_b (
      .clk(clk), .rst_n(rst_n), .bist(ifb)
   );
   inverter_bist_ctrl #(.NUM_VECTORS(4), .SETTLE_CYCLES(0), .ERR_W(8)) u_c (
      .clk(clk), .rst_n(rst_n), .bist(ifc)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   logic pass_exp;
   int   err_exp;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int c, input int w);
      int lim;
      lim = (1 << w) - 1;
      return (c > lim) ? lim : c;
   endfunction

   // mode: 0 good inverter, 1 dut_out stuck at 0, 2 random per-vector faults.
   // abort_k/reset_k: cycle index after the start edge to abort/reset at (-1 none).
   task automatic run_a(input int mode, input int abort_k, input int reset_k,
                        input bit hold_start);
      int   cnt;
      int   v;
      int   ph;
      bit   faulty;
      logic din;
      cnt = 0;
      ifa.start = 1'b1;
      ifa.abort = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < RUN; k++) begin
         v   = k / VPC;
         ph  = k % VPC;
         din = ((v % 2) != 0);
         chk("busy_run", ifa.busy, 1);
         chk("dut_in_run", ifa.dut_in, din);
         chk("done_run", ifa.done, 0);
         if (k == 0) begin
            chk("err_clr", ifa.err_count, 0);
            chk("pass_clr", ifa.pass, 0);
         end
         ifa.start = hold_start ? 1'b1 : 1'($urandom % 2);
         if (ph == VPC - 1) begin
            case (mode)
               0:       faulty = 1'b0;
               1:       faulty = (din == 1'b0);
               default: faulty = (($urandom % 3) == 0);
            endcase
            ifa.dut_out = faulty ? din : ~din;
            if (faulty) cnt++;
         end else begin
            ifa.dut_out = 1'($urandom % 2);
         end
         if (k == reset_k) begin
            rst_n = 1'b0;
            #1;
            chk("rst_busy", ifa.busy, 0);
            chk("rst_done", ifa.done, 0);
            chk("rst_dut_in", ifa.dut_in, 0);
            chk("rst_pass", ifa.pass, 0);
            chk("rst_err", ifa.err_count, 0);
            ifa.start = 1'b0;
            repeat (2) @(negedge clk);
            chk("rst_hold_done", ifa.done, 0);
            rst_n    = 1'b1;
            pass_exp = 1'b0;
            err_exp  = 0;
            return;
         end
         if (k == abort_k) begin
            ifa.abort = 1'b1;
            @(posedge clk); #1;
            ifa.abort = 1'b0;
            ifa.start = 1'b0;
            pass_exp  = 1'b0;
            err_exp   = sat(cnt, 8);
            chk("abort_busy", ifa.busy, 0);
            chk("abort_dut_in", ifa.dut_in, 0);
            chk("abort_done", ifa.done, 0);
            chk("abort_pass", ifa.pass, 0);
            chk("abort_err", ifa.err_count, err_exp);
            @(posedge clk); #1;
            chk("abort_no_done", ifa.done, 0);
            chk("abort_err_hold", ifa.err_count, err_exp);
            return;
         end
         @(posedge clk); #1;
      end
      err_exp  = sat(cnt, 8);
      pass_exp = (cnt == 0);
      chk("done_pulse", ifa.done, 1);
      chk("done_busy", ifa.busy, 0);
      chk("done_dut_in", ifa.dut_in, 0);
      chk("done_err", ifa.err_count, err_exp);
      chk("done_pass", ifa.pass, pass_exp);
      ifa.start   = hold_start;
      ifa.abort   = 1'($urandom % 2);
      ifa.dut_out = 1'($urandom % 2);
      @(posedge clk); #1;
      chk("idle_done", ifa.done, 0);
      chk("idle_busy", ifa.busy, 0);
      chk("idle_pass_hold", ifa.pass, pass_exp);
      chk("idle_err_hold", ifa.err_count, err_exp);
      ifa.abort = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int edges;
      ifa.start = 1'b0; ifa.abort = 1'b0; ifa.dut_out = 1'b0;
      ifb.start = 1'b0; ifb.abort = 1'b0;
      ifc.start = 1'b0; ifc.abort = 1'b0;
      pass_exp = 1'b0;
      err_exp  = 0;
      repeat (3) @(negedge clk);
      chk("reset_busy", ifa.busy, 0);
      chk("reset_done", ifa.done, 0);
      chk("reset_pass", ifa.pass, 0);
      chk("reset_err", ifa.err_count, 0);
      chk("reset_dut_in", ifa.dut_in, 0);
      rst_n = 1'b1;

      run_a(0, -1, -1, 1'b0);
      run_a(1, -1, -1, 1'b0);

      // abort together with start in IDLE: nothing starts, pass holds
      ifa.start = 1'b1;
      ifa.abort = 1'b1;
      @(posedge clk); #1;
      chk("abort_start_idle_busy", ifa.busy, 0);
      chk("abort_start_idle_pass", ifa.pass, pass_exp);
      ifa.start = 1'b0;
      ifa.abort = 1'b0;
      @(posedge clk); #1;
      chk("abort_start_idle_busy2", ifa.busy, 0);

      run_a(0, 5 * VPC + 1, -1, 1'b0);
      run_a(1, 4 * VPC + VPC - 1, -1, 1'b0);
      run_a(0, -1, 9 * VPC + VPC - 1, 1'b0);
      run_a(0, -1, -1, 1'b0);
      run_a(2, -1, -1, 1'b1);
      run_a(2, -1, -1, 1'b1);
      run_a(0, -1, -1, 1'b0);
      for (int i = 0; i < 3; i++) run_a(2, -1, -1, 1'b0);

      ifb.start = 1'b1;
      @(posedge clk); #1;
      ifb.start = 1'b0;
      edges = 0;
      while (ifb.done !== 1'b1 && edges < 300) begin
         @(posedge clk); #1;
         edges++;
      end
      chk("buf_done_time", edges, 64);
      chk("buf_err_sat", ifb.err_count, 7);
      chk("buf_pass", ifb.pass, 0);

      ifc.start = 1'b1;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      edges = 0;
      while (ifc.done !== 1'b1 && edges < 300) begin
         @(posedge clk); #1;
         edges++;
      end
      chk("fast_done_time", edges, 8);
      chk("fast_err", ifc.err_count, 0);
      chk("fast_pass", ifc.pass, 1);
      @(posedge clk); #1;
      chk("fast_done_once", ifc.done, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
